// File: rtl/mdu_arbiter.sv
`default_nettype none
// ============================================================================
// mdu_arbiter: two-requester round-robin front end for a shared mult/div unit.
// Rev 1.0
// ============================================================================
module mdu_arbiter #(
  parameter int unsigned WDT_CYCLES = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic [31:0] mdu_rs,
  output logic [31:0] mdu_rt,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        resp_valid,
  output logic        resp_id,
  output logic        resp_err,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  input  logic        resp_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Watchdog fires on the busy cycle that would bring the count to WDT_CYCLES.
  localparam logic [7:0] WDT_LAST = 8'(WDT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [7:0]  wdt_q, wdt_d;

  logic        idle;
  logic        grant1;
  logic        grant0;
  logic        accept;
  logic        in_flight;
  logic [2:0]  sel_op;

  // last_q holds the index of the most recent grant; on a tie the other side wins.
  assign idle    = (state_q == IDLE) && !reset;
  assign grant1  = req1_valid && (!req0_valid || !last_q);
  assign grant0  = req0_valid && !grant1;

  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel_op     = grant1 ? req1_op : req0_op;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    err_d   = err_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wdt_d   = wdt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d   = grant1;
          last_d = grant1;
          op_d   = sel_op;
          a_d    = grant1 ? req1_a : req0_a;
          b_d    = grant1 ? req1_b : req0_b;
          if (sel_op[2]) begin
            err_d   = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!mdu_busy) begin
          err_d   = 1'b0;
          hi_d    = mdu_hi;
          lo_d    = mdu_lo;
          state_d = RESP;
        end else if (wdt_q == WDT_LAST) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          state_d = RESP;
        end else begin
          wdt_d = wdt_q + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      err_q   <= err_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wdt_q   <= wdt_d;
    end
  end

  assign in_flight  = (state_q == ISSUE) || (state_q == WAIT);
  assign mdu_start  = (state_q == ISSUE);
  assign mdu_op     = in_flight ? op_q : 3'd0;
  assign mdu_rs     = in_flight ? a_q : 32'd0;
  assign mdu_rt     = in_flight ? b_q : 32'd0;

  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_valid && id_q;
  assign resp_err   = resp_valid && err_q;
  assign resp_hi    = resp_valid ? hi_q : 32'd0;
  assign resp_lo    = resp_valid ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mdu_arbiter: directed self-checking bench with a small mult/div unit model.
// Rev 1.0
// ============================================================================
module tb_mdu_arbiter;

  localparam int WDT = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_rs, mdu_rt;
  logic        mdu_busy = 1'b0;
  logic [31:0] mdu_hi = 32'd0;
  logic [31:0] mdu_lo = 32'd0;
  logic        resp_valid, resp_id, resp_err;
  logic [31:0] resp_hi, resp_lo;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;
  int busy_len = 2;
  bit stuck = 1'b0;
  int mcnt = 0;
  int start_cnt = 0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_rs = 32'd0;
  logic [31:0] m_rt = 32'd0;

  mdu_arbiter #(.WDT_CYCLES(WDT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_rs(mdu_rs), .mdu_rt(mdu_rt),
    .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mdu_calc(input logic [2:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt);
    logic signed [63:0] sa, sb;
    sa = {{32{rs[31]}}, rs};
    sb = {{32{rt[31]}}, rt};
    case (op)
      3'd0:    mdu_calc = sa * sb;
      3'd1:    mdu_calc = {32'd0, rs} * {32'd0, rt};
      3'd2:    mdu_calc = {$signed(rs) % $signed(rt), $signed(rs) / $signed(rt)};
      default: mdu_calc = {rs % rt, rs / rt};
    endcase
  endfunction

  // Unit model: busy for busy_len cycles after start, frozen while stuck is set.
  always @(posedge clk) begin
    if (mdu_start) begin
      start_cnt <= start_cnt + 1;
      mdu_busy  <= 1'b1;
      mcnt      <= busy_len;
      m_op      <= mdu_op;
      m_rs      <= mdu_rs;
      m_rt      <= mdu_rt;
    end else if (mdu_busy && !stuck) begin
      if (mcnt <= 1) begin
        mdu_busy         <= 1'b0;
        {mdu_hi, mdu_lo} <= mdu_calc(m_op, m_rs, m_rt);
      end
      mcnt <= mcnt - 1;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      cyc;
      n++;
    end while (!resp_valid && n < 80);
  endtask

  task automatic test_reset;
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    req0_op = 3'd0; req1_op = 3'd0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    cyc; cyc;
    checks++;
    if ({req0_ready, req1_ready, mdu_start, resp_valid, resp_id, resp_err} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {req0_ready, req1_ready, mdu_start, resp_valid, resp_id, resp_err});
    end
    checks++;
    if ({mdu_op, mdu_rs, mdu_rt} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mdu got op=%0d rs=%h rt=%h want 0", mdu_op, mdu_rs, mdu_rt);
    end
    checks++;
    if ({resp_hi, resp_lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_resp got %h want 0", {resp_hi, resp_lo});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    cyc;
  endtask

  task automatic test_tie_mult;
    int n;
    busy_len = 2;
    req0_op = 3'd0; req0_a = 32'hFFFF_FFFD; req0_b = 32'd5;
    req1_op = 3'd1; req1_a = 32'd9; req1_b = 32'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tie_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    cyc;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_a = 32'd100; req0_op = 3'd3;
    #1;
    checks++;
    if ({mdu_start, mdu_op, mdu_rs, mdu_rt} !== {1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5}) begin
      errors++;
      $display("FAIL issue got start=%b op=%0d rs=%h rt=%h want 1 0 fffffffd 00000005",
               mdu_start, mdu_op, mdu_rs, mdu_rt);
    end
    cyc;
    checks++;
    if ({mdu_start, mdu_op, mdu_rs} !== {1'b0, 3'd0, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL wait_hold got start=%b op=%0d rs=%h want 0 0 fffffffd",
               mdu_start, mdu_op, mdu_rs);
    end
    // n is counted from the accept edge; 2 busy cycles give a latency of 4.
    wait_resp(n);
    n = n + 1;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL mult_latency got %0d want 4", n);
    end
    checks++;
    if ({resp_valid, resp_id, resp_err, resp_hi, resp_lo} !==
        {3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      errors++;
      $display("FAIL mult_resp got v=%b id=%b err=%b hi=%h lo=%h want 1 0 0 ffffffff fffffff1",
               resp_valid, resp_id, resp_err, resp_hi, resp_lo);
    end
    resp_ready = 1'b1;
    cyc;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mult_release got resp_valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_alternate;
    int n;
    logic [31:0] exp_lo;
    reset = 1'b1; cyc; reset = 1'b0;
    busy_len = 1;
    req0_op = 3'd0; req0_a = 32'd2; req0_b = 32'd3;
    req1_op = 3'd1; req1_a = 32'd4; req1_b = 32'd5;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        cyc;
        n++;
      end
      checks++;
      if ({req1_ready, req0_ready} !== (i[0] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_grant%0d got r1=%b r0=%b want id %0d", i, req1_ready, req0_ready, i[0]);
      end
      cyc;
      wait_resp(n);
      exp_lo = i[0] ? 32'd20 : 32'd6;
      checks++;
      if ({resp_valid, resp_id, resp_lo} !== {1'b1, i[0], exp_lo}) begin
        errors++;
        $display("FAIL alt_resp%0d got v=%b id=%b lo=%0d want 1 %0d %0d",
                 i, resp_valid, resp_id, resp_lo, i[0], exp_lo);
      end
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      cyc;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    busy_len = 3;
    req1_op = 3'd3; req1_a = 32'd7; req1_b = 32'd2; req1_valid = 1'b1;
    #1;
    cyc;
    req1_valid = 1'b0;
    req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    wait_resp(n);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({resp_valid, resp_id, resp_err, resp_hi, resp_lo, req0_ready, req1_ready} !==
          {3'b110, 32'd1, 32'd3, 2'b00}) begin
        errors++;
        $display("FAIL hold%0d got v=%b id=%b err=%b hi=%0d lo=%0d r0=%b r1=%b want 1 1 0 1 3 0 0",
                 k, resp_valid, resp_id, resp_err, resp_hi, resp_lo, req0_ready, req1_ready);
      end
      cyc;
    end
    resp_ready = 1'b1;
    cyc;
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_hold got v=%b r0=%b want 0 1", resp_valid, req0_ready);
    end
    req0_valid = 1'b0;
    #1;
  endtask

  task automatic test_illegal;
    int starts;
    starts = start_cnt;
    req0_op = 3'd5; req0_a = 32'h1234; req0_b = 32'h5678; req0_valid = 1'b1;
    #1;
    cyc;
    req0_valid = 1'b0;
    cyc;
    checks++;
    if ({resp_valid, resp_id, resp_err, resp_hi, resp_lo} !== {3'b101, 64'd0}) begin
      errors++;
      $display("FAIL illegal_resp got v=%b id=%b err=%b hi=%h lo=%h want 1 0 1 0 0",
               resp_valid, resp_id, resp_err, resp_hi, resp_lo);
    end
    checks++;
    if (start_cnt !== starts) begin
      errors++;
      $display("FAIL illegal_start got %0d starts want 0", start_cnt - starts);
    end
    resp_ready = 1'b1;
    cyc;
    resp_ready = 1'b0;
  endtask

  task automatic test_watchdog;
    int n;
    bit seen;
    busy_len = 2; stuck = 1'b1;
    req1_op = 3'd0; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    #1;
    cyc;
    req1_valid = 1'b0;
    wait_resp(n);
    // One ISSUE cycle then WDT busy cycles in WAIT before the error response.
    checks++;
    if (n !== WDT + 1) begin
      errors++;
      $display("FAIL wdt_latency got %0d want %0d", n, WDT + 1);
    end
    checks++;
    if ({resp_valid, resp_id, resp_err, resp_hi, resp_lo} !== {3'b111, 64'd0}) begin
      errors++;
      $display("FAIL wdt_resp got v=%b id=%b err=%b hi=%h lo=%h want 1 1 1 0 0",
               resp_valid, resp_id, resp_err, resp_hi, resp_lo);
    end
    resp_ready = 1'b1;
    cyc;
    resp_ready = 1'b0;
    stuck = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid) seen = 1'b1;
      cyc;
    end
    checks++;
    if ({seen, mdu_busy} !== 2'b00) begin
      errors++;
      $display("FAIL wdt_after got resp_seen=%b busy=%b want 0 0", seen, mdu_busy);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    busy_len = 6;
    req0_op = 3'd1; req0_a = 32'd3; req0_b = 32'd4; req0_valid = 1'b1;
    #1;
    cyc;
    req0_valid = 1'b0;
    cyc; cyc; cyc;
    reset = 1'b1;
    cyc;
    checks++;
    if ({req0_ready, req1_ready, mdu_start, resp_valid, resp_err, mdu_op, mdu_rs, mdu_rt} !== 72'd0) begin
      errors++;
      $display("FAIL rst_wait got start=%b v=%b op=%0d rs=%h rt=%h want all 0",
               mdu_start, resp_valid, mdu_op, mdu_rs, mdu_rt);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid) seen = 1'b1;
      cyc;
    end
    checks++;
    if ({seen, mdu_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_no_resp got resp_seen=%b busy=%b want 0 0", seen, mdu_busy);
    end
  endtask

  initial begin
    test_reset;
    test_tie_mult;
    test_alternate;
    test_backpressure;
    test_illegal;
    test_watchdog;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_arbiter.md
MDU_ARBITER -- requirements
Module: mdu_arbiter

Interface
REQ-001 Parameter: WDT_CYCLES, default 31, sets the maximum number of cycles spent in WAIT before a watchdog error response (legal range 12..255).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 req0_valid, req1_valid  in  1 each  requester N presents an operation.
REQ-005 req0_op, req1_op  in  3 each  operation code: 0 mult, 1 multu, 2 div, 3 divu; 4..7 illegal.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  32 each  operands (a to rs, b to rt).
REQ-007 req0_ready, req1_ready  out  1 each  arbiter accepts requester N this cycle.
REQ-008 mdu_start  out  1  start pulse to the shared multiply/divide unit.
REQ-009 mdu_op  out  3  operation code to the unit.
REQ-010 mdu_rs, mdu_rt  out  32 each  operands to the unit.
REQ-011 mdu_busy  in  1  unit busy; goes high on the edge that samples start and low on the edge that updates HI/LO.
REQ-012 mdu_hi, mdu_lo  in  32 each  unit result registers.
REQ-013 resp_valid  out  1  response held for the requester.
REQ-014 resp_id  out  1  requester index of the response.
REQ-015 resp_err  out  1  set for an illegal opcode or a watchdog expiry.
REQ-016 resp_hi, resp_lo  out  32 each  result.
REQ-017 resp_ready  in  1  consumer takes the response.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 Readiness SHALL be restricted to IDLE: only there may any reqN_ready be 1, and at most one of them.
REQ-020 With one valid requester, that requester SHALL be readied.
REQ-021 With both requesters valid, the one not granted last SHALL be readied; the last-grant pointer SHALL update on each accept.
REQ-022 An accept SHALL occur when reqN_valid and reqN_ready are both 1; at that edge the arbiter SHALL latch op, a, b and id.
REQ-023 On accept of a legal op the FSM SHALL go IDLE to ISSUE; on accept of an illegal op it SHALL go IDLE to RESP with resp_err=1 and resp_hi=resp_lo=0, and the unit SHALL NOT be started.
REQ-024 In ISSUE, mdu_start SHALL be 1 for exactly one cycle, with mdu_op/mdu_rs/mdu_rt driven from the latched values; the FSM SHALL then go to WAIT and clear the watchdog counter.
REQ-025 mdu_op, mdu_rs and mdu_rt SHALL hold the latched values from ISSUE through WAIT; mdu_start SHALL be 0 in every other state.
REQ-026 In WAIT, while mdu_busy=1, the watchdog counter SHALL increment by 1 per cycle.
REQ-027 In WAIT, when mdu_busy=0, the arbiter SHALL capture mdu_hi/mdu_lo into resp_hi/resp_lo with resp_err=0 and go to RESP.
REQ-028 In WAIT, when the counter reaches WDT_CYCLES with mdu_busy still 1, the FSM SHALL go to RESP with resp_err=1 and resp_hi=resp_lo=0.
REQ-029 In RESP, resp_valid SHALL be 1 and resp_id/resp_err/resp_hi/resp_lo SHALL be stable until resp_ready=1.
REQ-030 On the edge where resp_valid and resp_ready are both 1, the FSM SHALL return to IDLE; the next accept SHALL be possible no earlier than the following cycle.
REQ-031 resp_valid SHALL be 0 in every state other than RESP.
REQ-032 Changes to reqN_op/a/b after accept SHALL NOT affect the operation in flight.
REQ-033 A requester whose valid drops before ready SHALL NOT be granted, and the pointer SHALL NOT change.
REQ-034 Timing: latency from accept to resp_valid SHALL be 2 + (number of busy cycles) for legal ops and 1 for illegal ops.

Reset
REQ-035 On reset the state SHALL be IDLE and the last-grant pointer SHALL select req0 on the first tie.
REQ-036 On reset, every output SHALL be 0: all ready, mdu_start, mdu_op, mdu_rs, mdu_rt, resp_* and the watchdog counter.
REQ-037 Reset asserted in any state, including mid-WAIT, SHALL abort the operation and discard the pending result; a subsequent mdu_busy fall SHALL produce no response.

Verification
REQ-038 Scenario: both requesters valid after reset, req0 mult a=-3 b=5 -> req0 granted first, mdu_start one cycle with op=0; after busy falls, resp_id=0, resp_hi=0xFFFFFFFF, resp_lo=0xFFFFFFF1.
REQ-039 Scenario: both requesters held valid for four transactions -> grants alternate 0,1,0,1, and each response carries the matching id.
REQ-040 Scenario: req1 divu a=7 b=2 with resp_ready held 0 for 5 cycles -> resp_valid held with hi=1, lo=3 and stable outputs; no ready asserted until the handshake.
REQ-041 Scenario: req0 op=5 -> resp_valid on the cycle after accept with resp_err=1, resp_hi=resp_lo=0, and mdu_start never asserted.
REQ-042 Scenario: mdu_busy stuck at 1 -> after WDT_CYCLES busy cycles, resp_err=1 and the FSM returns to IDLE after resp_ready.
REQ-043 Scenario: reset asserted during WAIT -> all outputs 0 on the next cycle, and no response when busy later falls.
